// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice roller.
// Used by dice_roller and dice_mask_gen; the DICE_REJECT_EN option lives in dice_roller.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DONE
  } dice_state_t;

  localparam int DICE_REJECT_W = 4;
  localparam int DICE_MAX_W    = 16;

  // Smallest all-ones value covering sides-1, found by smearing the top set bit downward.
  function automatic logic [DICE_MAX_W-1:0] dice_mask(input logic [DICE_MAX_W-1:0] sides);
    logic [DICE_MAX_W-1:0] v;
    logic [DICE_MAX_W-1:0] m;
    v = sides - DICE_MAX_W'(1);
    m = v;
    for (int i = 1; i < DICE_MAX_W; i++) begin
      m = m | (v >> i);
    end
    return m;
  endfunction

endpackage

// File: rtl/dice_mask_gen.sv
// Combinational sample mask for the latched die size.
// The mask is only meaningful for sides_q >= 2; other values never reach SAMPLE.
module dice_mask_gen
  import dice_pkg::*;
#(
  parameter int RAND_W = 8
) (
  input  logic [RAND_W-1:0] sides_q,
  output logic [RAND_W-1:0] mask
);

  assign mask = RAND_W'(dice_mask(DICE_MAX_W'(sides_q)));

endmodule

// File: rtl/dice_roller.sv
// Turns a free-running random byte stream into die rolls 1..N behind valid/ready handshakes.
// Define DICE_REJECT_EN for bounded rejection sampling; otherwise a single-cycle fold is used.
//
// state  | meaning
// IDLE   | waiting for a roll request (roll_ready=1)
// SAMPLE | masking rand_in until an in-range value is found or the fallback fires
// DONE   | result held until the consumer accepts it
module dice_roller
  import dice_pkg::*;
#(
  parameter int RAND_W       = 8,
  parameter int REJECT_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RAND_W-1:0]        rand_in,
  input  logic                     roll_valid,
  output logic                     roll_ready,
  input  logic [RAND_W-1:0]        sides,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [RAND_W-1:0]        result,
  output logic                     bad_sides,
  output logic [DICE_REJECT_W-1:0] rejects
);

  dice_state_t              state_q, state_d;
  logic [RAND_W-1:0]        sides_q, sides_d;
  logic [RAND_W-1:0]        result_q, result_d;
  logic                     bad_q, bad_d;
  logic [DICE_REJECT_W-1:0] rejects_q, rejects_d;
  logic [RAND_W-1:0]        mask;
  logic [RAND_W-1:0]        r;

`ifdef DICE_REJECT_EN
  localparam logic [DICE_REJECT_W-1:0] REJECT_MAX = DICE_REJECT_W'(REJECT_LIMIT);
`else
  logic unused_limit;
  assign unused_limit = ^REJECT_LIMIT;
`endif

  dice_mask_gen #(.RAND_W(RAND_W)) u_mask_gen (
    .sides_q (sides_q),
    .mask    (mask)
  );

  assign r = rand_in & mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sides_q   <= '0;
      result_q  <= '0;
      bad_q     <= 1'b0;
      rejects_q <= '0;
    end else begin
      state_q   <= state_d;
      sides_q   <= sides_d;
      result_q  <= result_d;
      bad_q     <= bad_d;
      rejects_q <= rejects_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sides_d   = sides_q;
    result_d  = result_q;
    bad_d     = bad_q;
    rejects_d = rejects_q;
    case (state_q)
      IDLE: begin
        if (roll_valid) begin
          sides_d   = sides;
          rejects_d = '0;
          result_d  = '0;
          bad_d     = 1'b0;
          if (sides == '0) begin
            bad_d   = 1'b1;
            state_d = DONE;
          end else if (sides == RAND_W'(1)) begin
            result_d = RAND_W'(1);
            state_d  = DONE;
          end else begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
`ifdef DICE_REJECT_EN
        if (r < sides_q) begin
          result_d = r + RAND_W'(1);
          state_d  = DONE;
        end else if (rejects_q < REJECT_MAX) begin
          rejects_d = rejects_q + DICE_REJECT_W'(1);
        end else begin
          // mask < 2*sides_q, so the folded value is always in range
          result_d = r - sides_q + RAND_W'(1);
          state_d  = DONE;
        end
`else
        result_d = ((r >= sides_q) ? (r - sides_q) : r) + RAND_W'(1);
        state_d  = DONE;
`endif
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign roll_ready   = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign bad_sides    = bad_q;
  assign rejects      = rejects_q;

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: stimulus pushes expected rolls, a monitor checks them.
// Expected values follow DICE_REJECT_EN when it is defined for the build.
module tb_dice_roller;

  localparam int LIMIT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rand_in = 8'h00;
  logic       roll_valid = 1'b0;
  logic       roll_ready;
  logic [7:0] sides = 8'h00;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic [7:0] result;
  logic       bad_sides;
  logic [3:0] rejects;

  dice_roller #(.RAND_W(8), .REJECT_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .rand_in      (rand_in),
    .roll_valid   (roll_valid),
    .roll_ready   (roll_ready),
    .sides        (sides),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .bad_sides    (bad_sides),
    .rejects      (rejects)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic       bad;
    logic [3:0] rej;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every DONE cycle is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && result_valid) begin
      if (sb.size() == 0) begin
        check("sb_depth_on_valid", sb.size(), 1);
      end else begin
        if (!seen) begin
          check("latency", cyc - sb[0].acc + 1, sb[0].lat);
          seen = 1'b1;
        end
        check("result", result, sb[0].res);
        check("bad_sides", bad_sides, sb[0].bad);
        check("rejects", rejects, sb[0].rej);
        check("roll_ready_in_done", roll_ready, 0);
        if (result_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic roll(input logic [7:0] s, input logic [7:0] r0, input logic [7:0] r1,
                      input logic [7:0] eres, input logic ebad, input logic [3:0] erej,
                      input int elat, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!roll_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!roll_ready) check("ready_timeout", roll_ready, 1);
    roll_valid = 1'b1;
    sides      = s;
    @(posedge clk); #1;
    e.res = eres; e.bad = ebad; e.rej = erej; e.lat = elat; e.acc = cyc;
    sb.push_back(e);
    roll_valid = 1'b0;
    sides      = 8'hAA;
    rand_in    = r0;
    @(posedge clk); #1;
    rand_in = r1;
    n = 0;
    while (!result_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("valid_timeout", result_valid, 1);
    for (int i = 0; i < hold; i++) begin
      roll_valid = i[0];
      sides      = 8'd3;
      @(posedge clk); #1;
    end
    roll_valid   = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    check("idle_roll_ready", roll_ready, 1);
    check("idle_result_valid", result_valid, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_roll_ready"}, roll_ready, 1);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_bad_sides"}, bad_sides, 0);
    check({tag, "_rejects"}, rejects, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // result_ready outside DONE must be ignored
    result_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("stray_ready_roll_ready", roll_ready, 1);
    check("stray_ready_valid", result_valid, 0);

    roll(8'd6,   8'h0D, 8'h0D, 8'd6, 1'b0, 4'd0, 2, 0);
    roll(8'd0,   8'h00, 8'h00, 8'd0, 1'b1, 4'd0, 1, 0);
    roll(8'd1,   8'h00, 8'h00, 8'd1, 1'b0, 4'd0, 1, 0);
    roll(8'd2,   8'hFE, 8'hFE, 8'd1, 1'b0, 4'd0, 2, 0);
`ifdef DICE_REJECT_EN
    roll(8'd6,   8'h0E, 8'h01, 8'd2,   1'b0, 4'd1,     3,         0);
    roll(8'd6,   8'hFF, 8'hFF, 8'd2,   1'b0, 4'(LIMIT), 2 + LIMIT, 0);
    roll(8'd255, 8'hFF, 8'hFE, 8'd255, 1'b0, 4'd1,     3,         0);
    roll(8'd9,   8'h3A, 8'h33, 8'd4,   1'b0, 4'd1,     3,         0);
`else
    roll(8'd6,   8'h0E, 8'h01, 8'd1, 1'b0, 4'd0, 2, 0);
    roll(8'd6,   8'hFF, 8'hFF, 8'd2, 1'b0, 4'd0, 2, 0);
    roll(8'd255, 8'hFF, 8'hFE, 8'd1, 1'b0, 4'd0, 2, 0);
    roll(8'd9,   8'h3A, 8'h33, 8'd2, 1'b0, 4'd0, 2, 0);
`endif
    // backpressure: consumer stalls 5 cycles while requests pulse
    roll(8'd4,   8'h0B, 8'h0B, 8'd4, 1'b0, 4'd0, 2, 5);

    // reset during SAMPLE discards the pending roll
    @(posedge clk); #1;
    roll_valid = 1'b1;
    sides      = 8'd6;
    @(posedge clk); #1;
    roll_valid = 1'b0;
    rand_in    = 8'hFF;
    check("mid_roll_in_sample", roll_ready, 0);
    #1 reset = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b1;
    roll(8'd6, 8'h02, 8'h02, 8'd3, 1'b0, 4'd0, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty_at_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
# dice_roller

Downstream consumer of the 8-bit free-running random number generator: turns its raw byte stream into unbiased die rolls in the range 1..N for game logic. Gameplay FSMs request a roll with a valid/ready handshake. The block masks and rejection-samples successive generator outputs, then holds the result until the consumer accepts it. Worst-case latency is bounded by a fallback path.

## Interface
- RAND_W, 8, width of the random input and of sides/result
- REJECT_LIMIT, 8, maximum rejected samples before the fallback path is taken (1..15)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rand_in  in  RAND_W  generator output; updates every cycle
- roll_valid  in  1  roll request
- roll_ready  out  1  block can accept a request
- sides  in  RAND_W  die size N, sampled on request handshake
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result  out  RAND_W  roll value 1..N (0 for an invalid request)
- bad_sides  out  1  request had sides < 1; valid with result
- rejects  out  4  rejected samples for the current result; valid with result

## Operation
- FSM states: IDLE, SAMPLE, DONE.
- IDLE: roll_ready=1. On roll_valid&&roll_ready, latch sides into sides_q and clear the reject counter.
  - sides==0: go to DONE with result=0, bad_sides=1.
  - sides==1: go to DONE with result=1.
  - Otherwise go to SAMPLE.
- mask = smallest all-ones value >= sides_q-1 (e.g. 6->7, 8->7, 9->15, 255->0xFF). Compute it combinationally from sides_q.
- SAMPLE: r = rand_in & mask. rand_in is read only in this state.
  - r < sides_q: result=r+1, go to DONE.
  - r >= sides_q and rejects < REJECT_LIMIT: increment rejects, stay in SAMPLE.
  - r >= sides_q and rejects == REJECT_LIMIT: fallback, result=r-sides_q+1, go to DONE. This is always in range because mask < 2*sides_q.
- DONE: result_valid=1. result, bad_sides and rejects are held stable. On result_valid&&result_ready, go to IDLE.
- roll_ready=0 in SAMPLE and DONE. A new request cannot be accepted in the same cycle a result is consumed.
- Arithmetic: RAND_W unsigned; r+1 cannot overflow because r < sides_q <= 255.

## Timing
- Reset values: state=IDLE, roll_ready=1, result_valid=0, result=0, bad_sides=0, rejects=0, sides_q=0.
- Request accepted at edge T:
  - sides <= 1: result_valid asserts at T+1.
  - Otherwise: first sample taken in cycle T+1; result_valid asserts at T+2+k, where k = rejects (0..REJECT_LIMIT).
- Worst-case latency is T+2+REJECT_LIMIT.
- result_valid falls on the edge after the handshake; roll_ready rises on that same edge.
- result_ready asserted while not in DONE is ignored. roll_valid outside IDLE is ignored and is not queued.
- Reset asserted mid-SAMPLE or mid-DONE: the block returns immediately (asynchronously) to reset values and discards the pending roll.

## Configuration
- DICE_REJECT_EN defined: rejection sampling as above; unbiased except on the fallback path.
- DICE_REJECT_EN undefined:
  - SAMPLE always completes in one cycle: result = (r >= sides_q ? r-sides_q : r)+1.
  - rejects is tied to 0. REJECT_LIMIT is unused.
  - Latency is fixed at T+2; slight bias is accepted.

## Structure
- Shared package dice_pkg holds:
  - state enum dice_state_t {IDLE, SAMPLE, DONE}
  - constant DICE_REJECT_W=4
  - function dice_mask(sides), returning the all-ones mask
- One natural sub-module: dice_mask_gen, the combinational mask from sides_q. The FSM and registers stay in dice_roller.

## Test plan
- Unbiased accept: sides=6, rand_in=0x0D in the first SAMPLE cycle -> r=5, result=6, rejects=0, result_valid at T+2.
- Single reject: sides=6, rand_in=0x0E then 0x01 -> one reject (r=6), result=2, rejects=1, result_valid at T+3.
- Fallback bound: sides=6, rand_in held at 0xFF, REJECT_LIMIT=8 -> r=7 rejected 8 times, fallback result=2, rejects=8, result_valid at T+10.
- Degenerate sides:
  - sides=0 -> result=0, bad_sides=1 at T+1.
  - sides=1 -> result=1, bad_sides=0 at T+1.
  - sides=255, rand_in 0xFF then 0xFE -> result=255, rejects=1.
- Backpressure: result_ready held low 5 cycles in DONE while roll_valid pulses -> result, bad_sides and rejects stable; roll_ready=0; no new request taken. IDLE is re-entered one cycle after result_ready=1.
- Reset mid-roll: reset=0 during SAMPLE -> all outputs at reset values immediately. After release, a new roll with sides=6 and rand_in=0x02 -> result=3.
